// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus arbiter and the device models on the segment.
package pci_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_HANDOVER = 2'd0,
    ST_PARK     = 2'd1,
    ST_GRANT    = 2'd2,
    ST_BUSY     = 2'd3
  } arb_state_e;

  // PCI bus commands used by the device models
  localparam logic [3:0] PCI_CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] PCI_CMD_MEM_WRITE = 4'b0111;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin picker: first active-low request after ptr, wrapping.
module pci_rr_pick import pci_pkg::*; #(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req_n,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [W-1:0] idx;

  // Scan distances N..1 so the nearest request after ptr is the last one written
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (!req_n[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin grants, bus parking, FRAME/IRDY ownership tracking.
module pci_arbiter import pci_pkg::*; #(
  parameter int N_MASTERS    = 4,
  parameter int PARK_MASTER  = 0,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_MASTERS-1:0]         REQ,
  input  logic                         FRAME,
  input  logic                         IRDY,
  output logic [N_MASTERS-1:0]         GNT,
  output logic [clog2(N_MASTERS)-1:0]  OWNER,
  output logic                         BUS_IDLE
);

  localparam int OW = clog2(N_MASTERS);
  localparam int CW = clog2(IDLE_TIMEOUT) + 1;
  localparam logic [OW-1:0]        PARK_IDX = OW'(PARK_MASTER);
  localparam logic [CW-1:0]        CNT_LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0]        CNT_MAX  = {CW{1'b1}};
  localparam logic [N_MASTERS-1:0] ALL_HI   = {N_MASTERS{1'b1}};

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 idle_q, idle_d;

  logic                 pick_vld;
  logic [OW-1:0]        pick_win;
  logic                 others_req;

  function automatic logic [N_MASTERS-1:0] onehot(input logic [OW-1:0] i);
    return N_MASTERS'(1) << i;
  endfunction

  pci_rr_pick #(.N(N_MASTERS), .W(OW)) u_pick (
    .req_n  (REQ),
    .ptr    (ptr_q),
    .valid  (pick_vld),
    .winner (pick_win)
  );

  // Any master other than the current owner asking for the bus
  assign others_req = |(~REQ & ~onehot(owner_q));

  // Next-state: grant selection, parking, idle timeout, preemption, turnaround
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idle_d  = FRAME & IRDY;
    case (state_q)
      ST_HANDOVER: begin
        if (pick_vld) begin
          gnt_d   = ~onehot(pick_win);
          owner_d = pick_win;
          ptr_d   = pick_win;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end else begin
          gnt_d   = ~onehot(PARK_IDX);
          owner_d = PARK_IDX;
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        if (!FRAME) begin
          state_d = ST_BUSY;
        end else if (pick_vld) begin
          if (pick_win == PARK_IDX) begin
            // parked master keeps its grant without a dead cycle
            ptr_d   = pick_win;
            cnt_d   = '0;
            state_d = ST_GRANT;
          end else begin
            gnt_d   = ALL_HI;
            state_d = ST_HANDOVER;
          end
        end
      end
      ST_GRANT: begin
        if (!FRAME) begin
          state_d = ST_BUSY;
        end else if (cnt_q >= CNT_LAST || REQ[owner_q]) begin
          gnt_d   = ALL_HI;
          state_d = ST_HANDOVER;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (FRAME && IRDY) begin
          gnt_d   = ALL_HI;
          state_d = ST_HANDOVER;
        end else if (others_req) begin
          // owner finishes its transaction but may not start another
          gnt_d = ALL_HI;
        end
      end
      default: begin
        gnt_d   = ALL_HI;
        state_d = ST_HANDOVER;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HANDOVER;
      gnt_q   <= ALL_HI;
      owner_q <= PARK_IDX;
      ptr_q   <= OW'(N_MASTERS - 1);
      cnt_q   <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  assign GNT      = gnt_q;
  assign OWNER    = owner_q;
  assign BUS_IDLE = idle_q;

endmodule
